// File: rtl/gray_counter_arbiter.sv
// Round-robin sequencer that shares one up/down Gray-code counter between two
// requesters, stepping it once per cycle for the granted run length.
module gray_counter_arbiter #(
    parameter int WIDTH = 4,
    parameter int STEPW = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             mode0,
    input  logic [STEPW-1:0] steps0,
    input  logic             req1,
    input  logic             mode1,
    input  logic [STEPW-1:0] steps1,
    output logic [1:0]       gnt,
    output logic             busy,
    output logic             done,
    output logic             done_id,
    output logic [WIDTH-1:0] gray
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] bin;
    logic [WIDTH-1:0] next_bin;
    logic [STEPW-1:0] remaining;
    logic             run_mode;
    logic             run_id;
    logic             last;

    logic             any_req;
    logic             winner;
    logic             win_mode;
    logic [STEPW-1:0] win_steps;

    // On a tie the requester that was not granted last wins.
    always_comb begin
        any_req   = req0 | req1;
        winner    = (req0 && req1) ? ~last : req1;
        win_mode  = winner ? mode1 : mode0;
        win_steps = winner ? steps1 : steps0;
        next_bin  = run_mode ? (bin + WIDTH'(1)) : (bin - WIDTH'(1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            bin       <= '0;
            gray      <= '0;
            gnt       <= 2'b00;
            busy      <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            remaining <= '0;
            run_mode  <= 1'b0;
            run_id    <= 1'b0;
            last      <= 1'b1;
        end else begin
            gnt <= 2'b00;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        gnt       <= winner ? 2'b10 : 2'b01;
                        busy      <= 1'b1;
                        last      <= winner;
                        run_id    <= winner;
                        run_mode  <= win_mode;
                        remaining <= win_steps;
                        if (win_steps == '0) begin
                            // Zero-length run completes in the grant cycle itself.
                            done    <= 1'b1;
                            done_id <= winner;
                            state   <= DONE;
                        end else begin
                            state <= RUN;
                        end
                    end
                end
                RUN: begin
                    bin       <= next_bin;
                    gray      <= next_bin ^ (next_bin >> 1);
                    remaining <= remaining - STEPW'(1);
                    if (remaining == STEPW'(1)) begin
                        done    <= 1'b1;
                        done_id <= run_id;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    done_id <= 1'b0;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_counter_arbiter.sv
// Directed bench for gray_counter_arbiter: each scenario compares
// {gnt, busy, done, gray} per cycle against hand-derived vectors.
module tb_gray_counter_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       req0, mode0, req1, mode1;
    logic [3:0] steps0, steps1;
    logic [1:0] gnt;
    logic       busy, done, done_id;
    logic [3:0] gray;

    int n_cmp  = 0;
    int n_fail = 0;

    gray_counter_arbiter #(.WIDTH(4), .STEPW(4)) dut (
        .clk     (clk),
        .reset   (reset),
        .req0    (req0),
        .mode0   (mode0),
        .steps0  (steps0),
        .req1    (req1),
        .mode1   (mode1),
        .steps1  (steps1),
        .gnt     (gnt),
        .busy    (busy),
        .done    (done),
        .done_id (done_id),
        .gray    (gray)
    );

    always #5 clk = ~clk;

    task automatic quiet_inputs();
        req0 = 1'b0; mode0 = 1'b0; steps0 = 4'd0;
        req1 = 1'b0; mode1 = 1'b0; steps1 = 4'd0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        quiet_inputs();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        reset = 1'b1;
        quiet_inputs();
        repeat (2) @(negedge clk);
        obs = {gnt, busy, done, gray};
        n_cmp++;
        if (obs !== 8'b00_0_0_0000) begin
            n_fail++;
            $display("[TB] FAIL reset_outputs: got %b, expected %b", obs, 8'b00_0_0_0000);
        end
        n_cmp++;
        if (done_id !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_done_id: got %b, expected 0", done_id);
        end
        reset = 1'b0;
    endtask

    task automatic test_up_run();
        logic [7:0] exp [5];
        logic [7:0] obs;
        exp = '{8'b01_1_0_0000, 8'b00_1_0_0001, 8'b00_1_0_0011,
                8'b00_1_1_0010, 8'b00_0_0_0010};
        req0 = 1'b1; mode0 = 1'b1; steps0 = 4'd3;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) req0 = 1'b0;
            obs = {gnt, busy, done, gray};
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("[TB] FAIL up_run[%0d]: got %b, expected %b", i, obs, exp[i]);
            end
            if (exp[i][4]) begin
                n_cmp++;
                if (done_id !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL up_run_id: got %b, expected 0", done_id);
                end
            end
        end
    endtask

    task automatic test_down_wrap();
        logic [7:0] exp [4];
        logic [7:0] obs;
        exp = '{8'b10_1_0_0000, 8'b00_1_0_1000, 8'b00_1_1_1001, 8'b00_0_0_1001};
        do_reset();
        req1 = 1'b1; mode1 = 1'b0; steps1 = 4'd2;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 0) req1 = 1'b0;
            obs = {gnt, busy, done, gray};
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("[TB] FAIL down_wrap[%0d]: got %b, expected %b", i, obs, exp[i]);
            end
            if (exp[i][4]) begin
                n_cmp++;
                if (done_id !== 1'b1) begin
                    n_fail++;
                    $display("[TB] FAIL down_wrap_id: got %b, expected 1", done_id);
                end
            end
        end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp [9];
        logic       exp_id [9];
        logic [7:0] obs;
        exp = '{8'b01_1_0_0000, 8'b00_1_1_0001, 8'b00_0_0_0001,
                8'b10_1_0_0001, 8'b00_1_1_0011, 8'b00_0_0_0011,
                8'b01_1_0_0011, 8'b00_1_1_0010, 8'b00_0_0_0010};
        exp_id = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        do_reset();
        req0 = 1'b1; mode0 = 1'b1; steps0 = 4'd1;
        req1 = 1'b1; mode1 = 1'b1; steps1 = 4'd1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            if (i == 0) req0 = 1'b0;
            if (i == 3) req1 = 1'b0;
            if (i == 5) begin req0 = 1'b1; req1 = 1'b1; end
            if (i == 6) begin req0 = 1'b0; req1 = 1'b0; end
            obs = {gnt, busy, done, gray};
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("[TB] FAIL round_robin[%0d]: got %b, expected %b", i, obs, exp[i]);
            end
            if (exp[i][4]) begin
                n_cmp++;
                if (done_id !== exp_id[i]) begin
                    n_fail++;
                    $display("[TB] FAIL round_robin_id[%0d]: got %b, expected %b", i, done_id, exp_id[i]);
                end
            end
        end
    endtask

    task automatic test_zero_steps();
        logic [7:0] exp [3];
        logic [7:0] obs;
        exp = '{8'b01_1_1_0010, 8'b00_0_0_0010, 8'b00_0_0_0010};
        req0 = 1'b1; mode0 = 1'b1; steps0 = 4'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 0) req0 = 1'b0;
            obs = {gnt, busy, done, gray};
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("[TB] FAIL zero_steps[%0d]: got %b, expected %b", i, obs, exp[i]);
            end
            if (exp[i][4]) begin
                n_cmp++;
                if (done_id !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL zero_steps_id: got %b, expected 0", done_id);
                end
            end
        end
    endtask

    task automatic test_wrap_15();
        logic [7:0] exp;
        logic [7:0] obs;
        logic [3:0] b;
        do_reset();
        req0 = 1'b1; mode0 = 1'b1; steps0 = 4'd15;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            b = 4'(i);
            if (i == 0)       exp = 8'b01_1_0_0000;
            else if (i < 15)  exp = {2'b00, 1'b1, 1'b0, b ^ (b >> 1)};
            else if (i == 15) exp = 8'b00_1_1_1000;
            else if (i == 16) exp = 8'b00_0_0_1000;
            else if (i == 17) exp = 8'b01_1_0_1000;
            else if (i == 18) exp = 8'b00_1_1_0000;
            else              exp = 8'b00_0_0_0000;
            if (i == 0 || i == 17) req0 = 1'b0;
            if (i == 16) begin req0 = 1'b1; steps0 = 4'd1; end
            obs = {gnt, busy, done, gray};
            n_cmp++;
            if (obs !== exp) begin
                n_fail++;
                $display("[TB] FAIL wrap_15[%0d]: got %b, expected %b", i, obs, exp);
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [7:0] exp [13];
        logic [7:0] obs;
        exp = '{8'b01_1_0_0000, 8'b00_1_0_0001, 8'b00_0_0_0000,
                8'b00_0_0_0000, 8'b00_0_0_0000, 8'b00_0_0_0000,
                8'b00_0_0_0000, 8'b00_0_0_0000, 8'b00_0_0_0000,
                8'b01_1_0_0000, 8'b00_1_0_0001, 8'b00_1_1_0011,
                8'b00_0_0_0011};
        do_reset();
        // Pointer is left at 0 by this run, so a tie after the abort tells a real reset apart.
        req0 = 1'b1; mode0 = 1'b1; steps0 = 4'd5;
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            if (i == 0) req0 = 1'b0;
            if (i == 1) reset = 1'b1;
            if (i == 2) reset = 1'b0;
            if (i == 8) begin
                req0 = 1'b1; mode0 = 1'b1; steps0 = 4'd2;
                req1 = 1'b1; mode1 = 1'b0; steps1 = 4'd2;
            end
            if (i == 9) begin req0 = 1'b0; req1 = 1'b0; end
            obs = {gnt, busy, done, gray};
            n_cmp++;
            if (obs !== exp[i]) begin
                n_fail++;
                $display("[TB] FAIL reset_abort[%0d]: got %b, expected %b", i, obs, exp[i]);
            end
            if (exp[i][4]) begin
                n_cmp++;
                if (done_id !== 1'b0) begin
                    n_fail++;
                    $display("[TB] FAIL reset_abort_id: got %b, expected 0", done_id);
                end
            end
        end
    endtask

    initial begin
        quiet_inputs();
        reset = 1'b1;
        test_reset();
        test_up_run();
        test_down_wrap();
        test_round_robin();
        test_zero_steps();
        test_wrap_15();
        test_reset_abort();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
